// File: rtl/mx_exp_scheduler_pkg.sv
// Shared constants and types for the shared-exponent scheduler.
package mx_exp_scheduler_pkg;

  localparam int FP16_W       = 16;
  localparam int BLK_N        = 32;
  localparam int BLK_W        = FP16_W * BLK_N;
  localparam int EXP_W        = 5;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_TREE_LAT = 5;

  // One buffered result: the requester that issued the block and its exponent.
  typedef struct packed {
    logic             src;
    logic [EXP_W-1:0] exp;
  } res_entry_t;

endpackage

// File: rtl/mx_sched_fifo.sv
// Synchronous FIFO with a registered occupancy count. Simultaneous read and
// write are allowed; a read when empty is ignored, and a write when full is
// dropped and flagged by an assertion (callers guarantee it never happens).
module mx_sched_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [W-1:0]                 wr_data_i,
  input  logic                         rd_en_i,
  output logic [W-1:0]                 rd_data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    full     = (count_q == FULL_CNT);
    do_wr    = wr_en_i && !full;
    do_rd    = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

  // Occupancy accounting upstream must make this impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(wr_en_i && full));

endmodule

// File: rtl/mx_exp_scheduler.sv
// Arbitrates two block requesters onto the shared-exponent tree under a
// credit pool, tracks the source of each issued block in order, and buffers
// tree results for a valid/ready consumer.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. Requester ready is combinational from the valids, the round-robin
// pointer and the registered occupancy counts; it never looks at res_ready.
// res_valid is high whenever a result is buffered and the head entry is held
// until res_ready is seen with it.
module mx_exp_scheduler
  import mx_exp_scheduler_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int TREE_LAT = DEF_TREE_LAT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  input  logic [BLK_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [BLK_W-1:0] req1_data,
  output logic             req1_ready,
  output logic             tree_enable,
  output logic [BLK_W-1:0] tree_data,
  input  logic             tree_done,
  input  logic [EXP_W-1:0] tree_max_exp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [EXP_W-1:0] res_exp,
  output logic             res_src,
  output logic             err_orphan
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  // prio_q names the requester that wins when both are valid.
  logic             prio_q, prio_d;
  logic             tree_en_q;
  logic [BLK_W-1:0] tree_data_q, tree_data_d;
  logic             err_orphan_q;

  logic [CW-1:0]    tag_cnt;
  logic [CW-1:0]    res_cnt;
  logic             tag_empty;
  logic             res_empty;
  logic             tag_head;
  res_entry_t       res_wr;
  res_entry_t       res_head;

  logic             credit_ok;
  logic             gnt0;
  logic             gnt1;
  logic             hs_any;
  logic             tag_pop;
  logic             res_pop;
  logic             orphan;

  // Credit check, grant, handshake and issue-register next state. A tag is
  // pushed at handshake time so the credit count already covers the block
  // in the very next cycle.
  always_comb begin
    credit_ok   = ({1'b0, tag_cnt} + {1'b0, res_cnt}) < DEPTH_C;
    gnt0        = req0_valid && (!req1_valid || !prio_q);
    gnt1        = req1_valid && (!req0_valid ||  prio_q);
    req0_ready  = gnt0 && credit_ok && !RST;
    req1_ready  = gnt1 && credit_ok && !RST;
    hs_any      = req0_ready || req1_ready;
    prio_d      = prio_q;
    tree_data_d = tree_data_q;
    if (req0_ready) begin
      prio_d      = 1'b1;
      tree_data_d = req0_data;
    end else if (req1_ready) begin
      prio_d      = 1'b0;
      tree_data_d = req1_data;
    end
    orphan      = tree_done && tag_empty;
    tag_pop     = tree_done && !tag_empty;
    res_pop     = !res_empty && res_ready;
    res_wr.src  = tag_head;
    res_wr.exp  = tree_max_exp;
  end

  // Issue register, arbitration pointer and sticky orphan flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio_q       <= 1'b0;
      tree_en_q    <= 1'b0;
      tree_data_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      tree_en_q    <= hs_any;
      tree_data_q  <= tree_data_d;
      err_orphan_q <= err_orphan_q | orphan;
    end
  end

  mx_sched_fifo #(
    .W     (1),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (hs_any),
    .wr_data_i (req1_ready),
    .rd_en_i   (tag_pop),
    .rd_data_o (tag_head),
    .empty_o   (tag_empty),
    .count_o   (tag_cnt)
  );

  mx_sched_fifo #(
    .W     ($bits(res_entry_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (tag_pop),
    .wr_data_i (res_wr),
    .rd_en_i   (res_pop),
    .rd_data_o (res_head),
    .empty_o   (res_empty),
    .count_o   (res_cnt)
  );

  assign tree_enable = tree_en_q;
  assign tree_data   = tree_data_q;
  assign res_valid   = !res_empty;
  assign res_exp     = res_empty ? '0 : res_head.exp;
  assign res_src     = res_empty ? 1'b0 : res_head.src;
  assign err_orphan  = err_orphan_q;

  // The credit pool must cover at least one full tree pipeline.
  a_depth_covers_tree: assert property (@(posedge CLK) DEPTH >= TREE_LAT);

endmodule

// File: tb/tb_mx_exp_scheduler.sv
// Bench for mx_exp_scheduler: randomized and directed stimulus, a tree model
// with fixed latency, and a cycle-level reference of credits, round-robin
// grant, issue and result delivery.
`timescale 1ns/1ps
module tb_mx_exp_scheduler;
  import mx_exp_scheduler_pkg::*;

  localparam int DEPTH    = 8;
  localparam int TREE_LAT = 5;

  // ---------------- clock / reset / signals ----------------
  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             req0_valid, req1_valid;
  logic [BLK_W-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             tree_enable;
  logic [BLK_W-1:0] tree_data;
  logic             tree_done;
  logic [EXP_W-1:0] tree_max_exp;
  logic             res_valid, res_ready;
  logic [EXP_W-1:0] res_exp;
  logic             res_src;
  logic             err_orphan;

  always #5 CLK = ~CLK;

  mx_exp_scheduler #(.DEPTH(DEPTH), .TREE_LAT(TREE_LAT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .tree_enable  (tree_enable),
    .tree_data    (tree_data),
    .tree_done    (tree_done),
    .tree_max_exp (tree_max_exp),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_exp      (res_exp),
    .res_src      (res_src),
    .err_orphan   (err_orphan)
  );

  // ---------------- bench state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [5:0]       exp_q[$];     // expected {src, exp} per accepted block
  logic [BLK_W-1:0] tdata_q[$];   // expected tree_data per issue
  logic [BLK_W-1:0] rq0[$], rq1[$];
  typedef struct { int due; logic [4:0] val; } pend_t;
  pend_t pend_q[$];

  // reference model: accepted, completed-by-tree and delivered block counts
  int   acc = 0, n_done = 0, n_pop = 0;
  logic prio_m = 1'b0, hs_prev = 1'b0, exp_orph = 1'b0;

  int dut_hs = 0, te_count = 0;
  int hs_cyc = -1, te_cyc = -1, rv_cyc = -1, first_hs = -1, last_hs = -1;
  int res_mode = 1;
  bit gap_en = 1'b0;
  bit inject_orphan = 1'b0;

  function automatic logic [4:0] max_exp(input logic [BLK_W-1:0] b);
    logic [4:0] m;
    logic [4:0] e;
    m = '0;
    for (int k = 0; k < BLK_N; k++) begin
      e = b[16*k+10 +: 5];
      if (e > m) m = e;
    end
    return m;
  endfunction

  function automatic logic [BLK_W-1:0] rand_block();
    logic [BLK_W-1:0] b;
    for (int k = 0; k < BLK_N; k++) b[16*k +: 16] = 16'($urandom);
    return b;
  endfunction

  task automatic chk(input string name, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- tree model ----------------
  // Counts cycles and returns max exponent TREE_LAT cycles after each issue.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    #1;
    tree_done    = 1'b0;
    tree_max_exp = '0;
    if (RST) begin
      pend_q.delete();
    end else if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      tree_done    = 1'b1;
      tree_max_exp = pend_q[0].val;
      pend_q.pop_front();
    end else if (inject_orphan) begin
      tree_done     = 1'b1;
      tree_max_exp  = 5'd7;
      inject_orphan = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    int  cred;
    bit  e_r0, e_r1, e_rv;
    if (RST) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_tree_enable", tree_enable, 0);
      chk("rst_tree_data", tree_data, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_exp_src", {res_src, res_exp}, 0);
      chk("rst_err_orphan", err_orphan, 0);
      acc = 0; n_done = 0; n_pop = 0;
      prio_m = 1'b0; hs_prev = 1'b0; exp_orph = 1'b0;
      exp_q.delete();
      tdata_q.delete();
    end else begin
      cred = DEPTH - (acc - n_pop);
      e_r0 = (cred > 0) && req0_valid && (!req1_valid || prio_m == 1'b0);
      e_r1 = (cred > 0) && req1_valid && (!req0_valid || prio_m == 1'b1);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        dut_hs++;
        if (hs_cyc < 0) hs_cyc = cyc;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end

      chk("tree_enable", tree_enable, hs_prev);
      if (tree_enable) begin
        te_count++;
        if (te_cyc < 0) te_cyc = cyc;
        if (tdata_q.size() > 0) chk("tree_data", tree_data, tdata_q.pop_front());
        pend_q.push_back('{due: cyc + TREE_LAT, val: max_exp(tree_data)});
      end

      e_rv = (n_done - n_pop) > 0;
      chk("res_valid", res_valid, e_rv);
      if (res_valid && rv_cyc < 0) rv_cyc = cyc;
      if (e_rv && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_order: result popped with empty expected queue (cycle %0d)", cyc);
        end else begin
          chk("res_src_exp", {res_src, res_exp}, exp_q.pop_front());
        end
        n_pop++;
      end

      chk("err_orphan", err_orphan, exp_orph);
      if (tree_done) begin
        if (acc == n_done) exp_orph = 1'b1;
        else n_done++;
      end

      hs_prev = e_r0 || e_r1;
      if (e_r0) begin
        exp_q.push_back({1'b0, max_exp(req0_data)});
        tdata_q.push_back(req0_data);
        if (rq0.size() > 0) void'(rq0.pop_front());
        acc++;
        prio_m = 1'b1;
      end else if (e_r1) begin
        exp_q.push_back({1'b1, max_exp(req1_data)});
        tdata_q.push_back(req1_data);
        if (rq1.size() > 0) void'(rq1.pop_front());
        acc++;
        prio_m = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
    req0_valid = (rq0.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    req0_data  = (rq0.size() > 0) ? rq0[0] : '0;
    req1_valid = (rq1.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    req1_data  = (rq1.size() > 0) ? rq1[0] : '0;
    res_ready  = (res_mode == 1) ? 1'b1 : (res_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (!(rq0.size() == 0 && rq1.size() == 0 && acc == n_pop) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: timeout after %0d cycles, accepted %0d delivered %0d", name, n, acc, n_pop);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [BLK_W-1:0] b;
    int n;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    res_ready = 0; tree_done = 0; tree_max_exp = '0;
    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    step();

    // Single block, max exponent 19: check issue and result latency.
    res_mode = 1;
    hs_cyc = -1; te_cyc = -1; rv_cyc = -1;
    for (int k = 0; k < BLK_N; k++)
      b[16*k +: 16] = {1'($urandom), 5'($urandom_range(0, 18)), 10'($urandom)};
    b[16*5+10 +: 5] = 5'd19;
    rq0.push_back(b);
    repeat (15) step();
    chk("single_hs_seen", (hs_cyc >= 0), 1);
    chk("single_issue_lat", te_cyc - hs_cyc, 1);
    chk("single_res_lat", rv_cyc - hs_cyc, 7);

    // Both requesters streaming 8 blocks each: alternate grants, one per cycle.
    first_hs = -1; last_hs = -1; te_count = 0;
    for (int i = 0; i < 8; i++) begin
      rq0.push_back(rand_block());
      rq1.push_back(rand_block());
    end
    drain(200, "stream_drain");
    chk("stream_issue_count", te_count, 16);
    chk("stream_back_to_back", last_hs - first_hs, 15);

    // Consumer stalled: the credit pool stops req0 after DEPTH blocks.
    res_mode = 0;
    dut_hs = 0;
    for (int i = 0; i < 12; i++) rq0.push_back(rand_block());
    repeat (30) step();
    chk("stall_hs_count", dut_hs, DEPTH);
    chk("stall_ready_low", req0_ready, 0);
    res_mode = 1;
    step();
    res_mode = 0;
    step();
    chk("stall_ready_back", req0_ready, 1);
    res_mode = 1;
    drain(200, "stall_drain");
    chk("stall_total_hs", dut_hs, 12);

    // Random traffic with random consumer back-pressure.
    res_mode = 2;
    gap_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (rq0.size() < 4 && $urandom_range(0, 1) == 1) rq0.push_back(rand_block());
      if (rq1.size() < 4 && $urandom_range(0, 1) == 1) rq1.push_back(rand_block());
      step();
    end
    res_mode = 1;
    gap_en = 1'b0;
    drain(300, "random_drain");

    // Orphan tree_done with nothing in flight.
    repeat (3) step();
    chk("orphan_clear_before", err_orphan, 0);
    inject_orphan = 1'b1;
    repeat (4) step();
    chk("orphan_set", err_orphan, 1);
    chk("orphan_no_result", res_valid, 0);
    repeat (5) step();
    chk("orphan_sticky", err_orphan, 1);

    // Mid-operation reset with 3 in flight and 2 buffered.
    res_mode = 0;
    for (int i = 0; i < 5; i++) rq0.push_back(rand_block());
    n = 0;
    while ((n_done - n_pop) != 2 && n < 60) begin
      step();
      n++;
    end
    chk("midrst_buffered", n_done - n_pop, 2);
    chk("midrst_inflight", acc - n_done, 3);
    RST = 1'b1;
    rq0.delete();
    rq1.delete();
    step();
    step();
    RST = 1'b0;
    repeat (10) step();
    chk("midrst_no_res", res_valid, 0);
    chk("midrst_orphan_cleared", err_orphan, 0);
    rq1.push_back(rand_block());
    res_mode = 1;
    drain(100, "post_reset_drain");
    chk("post_reset_res_count", n_pop, 1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mx_exp_scheduler.md
MX_EXP_SCHEDULER -- requirements
Module: mx_exp_scheduler

Interface
REQ-001 Parameter DEPTH, default 8, meaning: max blocks in flight plus blocks buffered awaiting result (credit pool).
REQ-002 Parameter TREE_LAT, default 5, meaning: cycles from tree_enable to tree_done of the shared-exponent tree; DEPTH SHALL be >= TREE_LAT.
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 offers one 32-element FP16 block.
REQ-006 req0_data / req1_data  input  512  block, element k at bits [16k+15:16k].
REQ-007 req0_ready / req1_ready  output  1  block accepted when valid and ready are high in the same cycle.
REQ-008 tree_enable  output  1  one-cycle issue pulse to the exponent tree.
REQ-009 tree_data  output  512  block presented to the tree, stable while tree_enable is high.
REQ-010 tree_done  input  1  tree result valid pulse.
REQ-011 tree_max_exp  input  5  tree result, sampled when tree_done is high.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_exp  output  5  shared exponent.
REQ-015 res_src  output  1  requester that issued the block.
REQ-016 err_orphan  output  1  sticky: tree_done seen with no block in flight.

Function
REQ-017 credits = DEPTH - inflight - res_count; a requester SHALL see ready=1 only when credits > 0 and it holds the grant.
REQ-018 Grant: round-robin over two requesters; at most one grant per cycle; when both are valid, the requester not granted last SHALL win; a sole valid requester SHALL win regardless of pointer; the pointer SHALL update only on a completed handshake.
REQ-019 Ready SHALL be combinational from valid, pointer and credits; ready SHALL NOT depend on res_ready in the same cycle.
REQ-020 A handshake in cycle N SHALL produce tree_enable=1 with registered tree_data in cycle N+1; back-to-back issue, one per cycle, SHALL be supported.
REQ-021 On each issue, the granted source id SHALL be pushed into an in-order tag FIFO (DEPTH entries); inflight increments.
REQ-022 On tree_done, the tag FIFO SHALL pop, and {tag, tree_max_exp} SHALL be written to a result FIFO (DEPTH entries); inflight decrements, res_count increments.
REQ-023 res_valid SHALL be high whenever the result FIFO is non-empty; res_exp/res_src show the head entry; pop on res_valid && res_ready; first-word latency: res_valid high in cycle M+1 after tree_done in cycle M.
REQ-024 Simultaneous issue, tree_done and result pop in one cycle SHALL all take effect; counters SHALL net correctly (no lost or duplicated credit).
REQ-025 Results SHALL be delivered in issue order.
REQ-026 tree_done with empty tag FIFO SHALL be dropped and set err_orphan until reset.
REQ-027 The result FIFO cannot overflow by construction (REQ-017); a write to a full FIFO is a design error flagged by an assertion.

Reset
REQ-028 On RST: ready outputs 0, tree_enable 0, tree_data 0, res_valid 0, res_exp 0, res_src 0, err_orphan 0, pointer favours requester 0, both FIFOs empty, inflight 0.
REQ-029 RST asserted mid-operation SHALL discard all in-flight tags and buffered results; the tree is reset from the same source.

Structure
REQ-030 Shared package SHALL hold FP16 width (16), block size (32), exponent width (5), default DEPTH and TREE_LAT.
REQ-031 One sub-module, mx_sched_fifo (parameterised width/depth, sync, registered count), instantiated twice: tag FIFO (1 bit) and result FIFO (6 bits).

Verification
REQ-032 Single block from req0, tree model latency 5, res_ready=1: handshake cycle 0 -> tree_enable cycle 1, tree_done cycle 6, res_valid cycle 7 with res_src=0, res_exp = tree value (e.g. 5'd19).
REQ-033 Both requesters valid continuously for 8 blocks -> grants alternate 0,1,0,1..., results in same order, one issue per cycle.
REQ-034 res_ready=0, req0 streaming -> exactly 8 handshakes then req0_ready=0; one res pop -> req0_ready returns next cycle; nothing lost.
REQ-035 Issue, tree_done and res pop in same cycle with credits=1 -> credits stay 1, counts consistent.
REQ-036 Inject tree_done with nothing in flight -> no result written, err_orphan=1 until RST.
REQ-037 RST asserted with 3 in flight and 2 buffered -> all outputs at reset values next edge; no res_valid after release until a new block is issued.
